// File: rtl/dmem_bytelane_if.sv
// Request/response bundle between the load/store unit (master) and dmem_bytelane (slave).
// A request transfers on a rising edge where req_valid & req_ready; req fields are only meaningful
// while req_valid is high; rsp_valid is a one-cycle strobe per accepted request and rsp_rdata/rsp_err
// hold until the next strobe.
interface dmem_bytelane_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte/half/word data memory with sign/zero-extended loads, req/rsp handshake and WAIT_CYCLES stalls.
// Optional misaligned/reserved-size trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_bytelane #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset,
    dmem_bytelane_if.slave  bus,
    output logic [1:0]      dbg_state
);
    localparam int IW     = $clog2(DEPTH_WORDS);
    localparam bit DIRECT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t          state, state_next;
    logic [3:0]      wait_cnt;
    logic            we_q, uns_q;
    logic [IW+1:0]   addr_q;
    logic [1:0]      size_q;
    logic [31:0]     wdata_q;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rdata_q;
    logic            err_q;

    logic            accept, commit, mis;
    logic            c_we, c_uns, is_byte, is_half;
    logic [IW+1:0]   c_addr;
    logic [1:0]      c_size;
    logic [31:0]     c_wdata, rd_word, wlanes, ld;
    logic [3:0]      be;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic            unused_addr_hi;

    assign bus.req_ready = (state == S_IDLE) || (state == S_RESP);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state;
    assign accept        = bus.req_valid && bus.req_ready;
    assign unused_addr_hi = ^bus.req_addr[31:IW+2];

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept)
                    state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                else
                    state_next = S_IDLE;
            end
            S_WAIT:  if (wait_cnt == 4'd0) state_next = S_RESP;
            default: state_next = S_IDLE;
        endcase
    end

    // Entering RESP is the commit edge; without wait states it coincides with the accept edge,
    // so the live request is used instead of the captured copy.
    assign commit  = (state_next == S_RESP);
    assign c_we    = DIRECT ? bus.req_we            : we_q;
    assign c_uns   = DIRECT ? bus.req_unsigned      : uns_q;
    assign c_addr  = DIRECT ? bus.req_addr[IW+1:0]  : addr_q;
    assign c_size  = DIRECT ? bus.req_size          : size_q;
    assign c_wdata = DIRECT ? bus.req_wdata         : wdata_q;
    assign is_byte = (c_size == 2'b00);
    assign is_half = (c_size == 2'b01);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (is_half && c_addr[0]) || ((c_size == 2'b10) && (c_addr[1:0] != 2'b00))
                 || (c_size == 2'b11);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        be       = 4'b1111;
        wlanes   = c_wdata;
        rd_word  = mem[c_addr[IW+1:2]];
        byte_sel = rd_word[{c_addr[1:0], 3'b000} +: 8];
        half_sel = c_addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld       = rd_word;
        if (is_byte) begin
            be     = 4'b0001 << c_addr[1:0];
            wlanes = {4{c_wdata[7:0]}};
            ld     = {{24{~c_uns & byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            be     = c_addr[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{c_wdata[15:0]}};
            ld     = {{16{~c_uns & half_sel[15]}}, half_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_we && !mis && !reset) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[c_addr[IW+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            size_q   <= 2'b00;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q     <= bus.req_we;
                uns_q    <= bus.req_unsigned;
                addr_q   <= bus.req_addr[IW+1:0];
                size_q   <= bus.req_size;
                wdata_q  <= bus.req_wdata;
                wait_cnt <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                rdata_q <= (c_we || mis) ? 32'd0 : ld;
                err_q   <= mis;
            end
        end
    end
endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane: one instance without wait states, one with WAIT_CYCLES=3.
// Expected responses (data, error, retire cycle) are queued at accept and popped by per-DUT monitors.
module tb_dmem_bytelane;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v0 = 1'b0, v3 = 1'b0;
    logic        f_we = 1'b0, f_uns = 1'b0;
    logic [31:0] f_addr = 32'd0, f_wdata = 32'd0;
    logic [1:0]  f_size = 2'b00;
    logic [1:0]  st0, st3;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [48:0] exp0_q[$];
    logic [48:0] exp3_q[$];

    dmem_bytelane_if bus0();
    dmem_bytelane_if bus3();

    assign bus0.req_valid = v0;       assign bus3.req_valid = v3;
    assign bus0.req_we = f_we;        assign bus3.req_we = f_we;
    assign bus0.req_addr = f_addr;    assign bus3.req_addr = f_addr;
    assign bus0.req_size = f_size;    assign bus3.req_size = f_size;
    assign bus0.req_unsigned = f_uns; assign bus3.req_unsigned = f_uns;
    assign bus0.req_wdata = f_wdata;  assign bus3.req_wdata = f_wdata;

    dmem_bytelane #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .dbg_state(st0));
    dmem_bytelane #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .dbg_state(st3));

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // driver
    task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, input logic [31:0] er,
                         input logic ee, input bit push);
        int n;
        int snap;
        @(negedge clk);
        f_we = we; f_addr = addr; f_size = sz; f_uns = uns; f_wdata = wd;
        if (d == 0) v0 = 1'b1; else v3 = 1'b1;
        n = 0;
        while (!((d == 0) ? bus0.req_ready : bus3.req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("ready_timeout", 32'd1, 32'd0);
            v0 = 1'b0; v3 = 1'b0;
            return;
        end
        snap = cyc;
        @(posedge clk);
        if (push) begin
            if (d == 0) exp0_q.push_back({16'(snap + 1), ee, er});
            else        exp3_q.push_back({16'(snap + 4), ee, er});
        end
        #1;
        v0 = 1'b0; v3 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp0_q.size() != 0 || exp3_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp0_q.size() + exp3_q.size()), 32'd0);
    endtask

    task automatic run_suite(input int d);
        issue(d, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0, 1);
        issue(d, 0, 32'h13, 2'b00, 0, 32'h0, 32'hFFFFFFDE, 0, 1);
        issue(d, 0, 32'h13, 2'b00, 1, 32'h0, 32'h000000DE, 0, 1);
        issue(d, 0, 32'h12, 2'b01, 0, 32'h0, 32'hFFFFDEAD, 0, 1);
        issue(d, 0, 32'h10, 2'b01, 1, 32'h0, 32'h0000BEEF, 0, 1);
        issue(d, 0, 32'h11, 2'b00, 0, 32'h0, 32'hFFFFFFBE, 0, 1);
        issue(d, 0, 32'h10, 2'b00, 1, 32'h0, 32'h000000EF, 0, 1);
        issue(d, 1, 32'h11, 2'b00, 0, 32'hFFFFFF5A, 32'h0, 0, 1);
        issue(d, 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEAD5AEF, 0, 1);
        issue(d, 1, 32'h12, 2'b01, 0, 32'hABCD1234, 32'h0, 0, 1);
        issue(d, 0, 32'h10, 2'b10, 0, 32'h0, 32'h12345AEF, 0, 1);
        issue(d, 0, 32'h80000010, 2'b10, 0, 32'h0, 32'h12345AEF, 0, 1);
        issue(d, 1, 32'h100, 2'b10, 0, 32'hA5A50001, 32'h0, 0, 1);
        issue(d, 1, 32'h0FC, 2'b10, 0, 32'h0BADF00D, 32'h0, 0, 1);
        issue(d, 0, 32'h000, 2'b10, 0, 32'h0, 32'hA5A50001, 0, 1);
        issue(d, 0, 32'h0FC, 2'b10, 0, 32'h0, 32'h0BADF00D, 0, 1);
        issue(d, 0, 32'h100, 2'b10, 0, 32'h0, 32'hA5A50001, 0, 1);
        issue(d, 1, 32'h20, 2'b10, 0, 32'h01020304, 32'h0, 0, 1);
        issue(d, 1, 32'h22, 2'b10, 0, 32'hCAFEF00D, 32'h0, TRAP, 1);
        issue(d, 0, 32'h20, 2'b10, 0, 32'h0, TRAP ? 32'h01020304 : 32'hCAFEF00D, 0, 1);
        issue(d, 0, 32'h20, 2'b11, 0, 32'h0, TRAP ? 32'h0 : 32'hCAFEF00D, TRAP, 1);
        issue(d, 0, 32'h21, 2'b01, 0, 32'h0, TRAP ? 32'h0 : 32'hFFFFF00D, TRAP, 1);
        drain();
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        logic [48:0] e;
        if (bus0.rsp_valid) begin
            if (exp0_q.size() == 0) begin
                chk("rsp0_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp0_q.pop_front();
                chk("rsp0_rdata", bus0.rsp_rdata, e[31:0]);
                chk("rsp0_err", 32'(bus0.rsp_err), 32'(e[32]));
                chk("rsp0_cycle", 32'(cyc[15:0]), 32'(e[48:33]));
            end
        end
    end

    always @(negedge clk) begin
        logic [48:0] e;
        if (bus3.rsp_valid) begin
            if (exp3_q.size() == 0) begin
                chk("rsp3_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp3_q.pop_front();
                chk("rsp3_rdata", bus3.rsp_rdata, e[31:0]);
                chk("rsp3_err", 32'(bus3.rsp_err), 32'(e[32]));
                chk("rsp3_cycle", 32'(cyc[15:0]), 32'(e[48:33]));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready0"}, 32'(bus0.req_ready), 32'd1);
        chk({tag, "_valid0"}, 32'(bus0.rsp_valid), 32'd0);
        chk({tag, "_rdata0"}, bus0.rsp_rdata, 32'd0);
        chk({tag, "_err0"}, 32'(bus0.rsp_err), 32'd0);
        chk({tag, "_ready3"}, 32'(bus3.req_ready), 32'd1);
        chk({tag, "_valid3"}, 32'(bus3.rsp_valid), 32'd0);
        chk({tag, "_rdata3"}, bus3.rsp_rdata, 32'd0);
        chk({tag, "_err3"}, 32'(bus3.rsp_err), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        run_suite(0);
        run_suite(3);

        // a store aborted by reset during its wait states must leave the word untouched
        issue(3, 1, 32'h40, 2'b10, 0, 32'h11111111, 32'h0, 0, 1);
        drain();
        issue(3, 1, 32'h40, 2'b10, 0, 32'h22222222, 32'h0, 0, 0);
        @(negedge clk);
        chk("ready_in_wait", 32'(bus3.req_ready), 32'd0);
        chk("state_in_wait", 32'(st3), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        issue(3, 0, 32'h40, 2'b10, 0, 32'h0, 32'h11111111, 0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
